// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional feature macro used by this slice: CLKDIV_SYNC_EN.
package clk_div_pkg;

  localparam int          CLKDIV_CW           = 16;
  localparam int          CLKDIV_DEFAULT_HALF = 50000;
  localparam int unsigned SYS_CLK_HZ          = 100_000_000;

  // Half-period in system clock cycles for a wanted output frequency.
  function automatic int unsigned half_for_hz(input int unsigned f);
    if (f == 0) return 0;
    return SYS_CLK_HZ / (2 * f);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active half-period, shadow, divided clock and tick.
// With CLKDIV_SYNC_EN defined a sync_i input restarts the channel for phase alignment.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW           = CLKDIV_CW,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync_i,
`endif
  input  logic          en_i,
  input  logic          ld_i,
  input  logic [CW-1:0] val_i,
  output logic          clk_out_o,
  output logic          tick_o,
  output logic          err_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          restart;
  logic          term;

`ifdef CLKDIV_SYNC_EN
  assign restart = !en_i || sync_i;
`else
  assign restart = !en_i;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    shadow_d  = shadow_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    term      = (cnt_q == half_q - CW'(1));

    // A zero half-period would stall the channel, so it is refused and flagged.
    if (ld_i) begin
      if (val_i != '0) shadow_d = val_i;
      else             err_d    = 1'b1;
    end

    if (restart) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      half_d    = shadow_d;
    end else if (term) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = ~clk_out_q;
      half_d    = shadow_d;
    end else begin
      cnt_d     = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      half_q    <= CW'(DEFAULT_HALF);
      shadow_q  <= CW'(DEFAULT_HALF);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign err_o     = err_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator built from clk_div_chan.
// Define CLKDIV_SYNC_EN to add the sync input that phase-aligns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int CW           = CLKDIV_CW,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    div_ld,
  input  logic [NCH*CW-1:0] div_val,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic              cfg_err
);

  logic [NCH-1:0] err;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .CW           (CW),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
`ifdef CLKDIV_SYNC_EN
      .sync_i    (sync),
`endif
      .en_i      (ch_en[i]),
      .ld_i      (div_ld[i]),
      .val_i     (div_val[i*CW +: CW]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .err_o     (err[i])
    );
  end

  // The error flags are sticky registers, so the OR stays glitch-free.
  assign cfg_err = |err;

endmodule
